// File: rtl/snake_body_engine_if.sv
// Bus bundle between the game control FSM / drawing sequencer and the snake body engine.
// The master side issues commands and read indices; the slave side is the engine.
interface snake_body_engine_if #(
   parameter int X_W   = 8,
   parameter int Y_W   = 7,
   parameter int LEN_W = 8
);
   logic             start;
   logic             step;
   logic [1:0]       dir;
   logic             grow;
   logic [LEN_W-1:0] rd_idx;
   logic [X_W-1:0]   rd_x;
   logic [Y_W-1:0]   rd_y;
   logic [X_W-1:0]   head_x;
   logic [Y_W-1:0]   head_y;
   logic [LEN_W-1:0] length;
   logic [1:0]       cur_dir;
   logic             busy;
   logic             done;
   logic             dead;

   modport master (
      output start, step, dir, grow, rd_idx,
      input  rd_x, rd_y, head_x, head_y, length, cur_dir, busy, done, dead
   );

   modport slave (
      input  start, step, dir, grow, rd_idx,
      output rd_x, rd_y, head_x, head_y, length, cur_dir, busy, done, dead
   );
endinterface

// File: rtl/snake_body_engine.sv
// Snake body store and movement engine: keeps the segment list, moves/grows the
// snake one cell per step, checks wall and self collisions with a one-compare-per-
// cycle scan, and serves segment coordinates through a registered read port.
module snake_body_engine #(
   parameter int GRID_W   = 160,
   parameter int GRID_H   = 120,
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int MAX_LEN  = 128,
   parameter int INIT_LEN = 4,
   parameter int LEN_W    = $clog2(MAX_LEN + 1)
) (
   input logic                clk,
   input logic                reset,
   snake_body_engine_if.slave bus
);
   localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   typedef enum logic [1:0] {IDLE, MOVE, SCAN, DONE} state_t;

   state_t           state;
   logic [X_W-1:0]   seg_x [MAX_LEN];
   logic [Y_W-1:0]   seg_y [MAX_LEN];
   logic [X_W-1:0]   head_x;
   logic [Y_W-1:0]   head_y;
   logic [LEN_W-1:0] length;
   logic [LEN_W-1:0] scan_idx;
   logic [1:0]       cur_dir;
   logic [1:0]       mv_dir;
   logic             mv_grow;
   logic             busy;
   logic             done;
   logic             dead;
   logic [X_W-1:0]   rd_x;
   logic [Y_W-1:0]   rd_y;

   logic [X_W-1:0]   nxt_x;
   logic [Y_W-1:0]   nxt_y;
   logic             nxt_wall;
   logic [LEN_W-1:0] len_post;
   logic [1:0]       req_dir;

   // Pick the direction to latch: a direct reversal is refused for a body longer than one cell.
   always_comb begin
      req_dir = bus.dir;
      if ((length > LEN_W'(1)) && (bus.dir == (cur_dir ^ 2'b01))) begin
         req_dir = cur_dir;
      end
   end

   // Candidate head one cell along the latched direction, its wall test and the post-move length.
   always_comb begin
      nxt_x = head_x;
      nxt_y = head_y;
      case (mv_dir)
         2'b00:   nxt_x = head_x - X_W'(1);
         2'b01:   nxt_x = head_x + X_W'(1);
         2'b10:   nxt_y = head_y + Y_W'(1);
         default: nxt_y = head_y - Y_W'(1);
      endcase
      nxt_wall = (nxt_x == '0) || (nxt_x == X_W'(GRID_W - 1)) ||
                 (nxt_y == '0) || (nxt_y == Y_W'(GRID_H - 1));
      len_post = length;
      if (mv_grow && (length < LEN_W'(MAX_LEN))) begin
         len_post = length + LEN_W'(1);
      end
   end

   // Control FSM together with the segment store; all outputs except the read port live here.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         head_x   <= '0;
         head_y   <= '0;
         length   <= '0;
         scan_idx <= '0;
         cur_dir  <= 2'b01;
         mv_dir   <= 2'b01;
         mv_grow  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         dead     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  for (int i = 0; i < INIT_LEN; i++) begin
                     seg_x[i] <= X_W'(GRID_W / 2 - i);
                     seg_y[i] <= Y_W'(GRID_H / 2);
                  end
                  head_x  <= X_W'(GRID_W / 2);
                  head_y  <= Y_W'(GRID_H / 2);
                  length  <= LEN_W'(INIT_LEN);
                  cur_dir <= 2'b01;
                  dead    <= 1'b0;
               end else if (bus.step && (length != '0) && !dead) begin
                  mv_dir  <= req_dir;
                  mv_grow <= bus.grow;
                  busy    <= 1'b1;
                  state   <= MOVE;
               end
            end
            MOVE: begin
               if (nxt_wall) begin
                  dead  <= 1'b1;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  for (int i = MAX_LEN - 1; i > 0; i--) begin
                     seg_x[i] <= seg_x[i-1];
                     seg_y[i] <= seg_y[i-1];
                  end
                  seg_x[0] <= nxt_x;
                  seg_y[0] <= nxt_y;
                  head_x   <= nxt_x;
                  head_y   <= nxt_y;
                  length   <= len_post;
                  cur_dir  <= mv_dir;
                  scan_idx <= LEN_W'(1);
                  if (len_post == LEN_W'(1)) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     state <= SCAN;
                  end
               end
            end
            SCAN: begin
               if ((seg_x[scan_idx[IDX_W-1:0]] == head_x) && (seg_y[scan_idx[IDX_W-1:0]] == head_y)) begin
                  dead  <= 1'b1;
                  done  <= 1'b1;
                  state <= DONE;
               end else if (scan_idx == (length - LEN_W'(1))) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  scan_idx <= scan_idx + LEN_W'(1);
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Registered read port; indices beyond the live body read as zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_x <= '0;
         rd_y <= '0;
      end else if (bus.rd_idx < length) begin
         rd_x <= seg_x[bus.rd_idx[IDX_W-1:0]];
         rd_y <= seg_y[bus.rd_idx[IDX_W-1:0]];
      end else begin
         rd_x <= '0;
         rd_y <= '0;
      end
   end

   assign bus.rd_x    = rd_x;
   assign bus.rd_y    = rd_y;
   assign bus.head_x  = head_x;
   assign bus.head_y  = head_y;
   assign bus.length  = length;
   assign bus.cur_dir = cur_dir;
   assign bus.busy    = busy;
   assign bus.done    = done;
   assign bus.dead    = dead;
endmodule

// File: tb/tb_snake_body_engine.sv
// Testbench for snake_body_engine: directed scenarios plus a randomized run, all
// checked every cycle against a queue-based model of the snake.
module tb_snake_body_engine;
   localparam int GRID_W    = 160;
   localparam int GRID_H    = 120;
   localparam int X_W       = 8;
   localparam int Y_W       = 7;
   localparam int MAX_LEN   = 128;
   localparam int INIT_LEN  = 4;
   localparam int LEN_W     = $clog2(MAX_LEN + 1);
   localparam int SAT_MAX   = 6;
   localparam int SAT_LEN_W = $clog2(SAT_MAX + 1);

   typedef struct {
      int x;
      int y;
   } coord_t;

   logic clk = 1'b0;
   logic reset = 1'b1;

   snake_body_engine_if #(.X_W(X_W), .Y_W(Y_W), .LEN_W(LEN_W))     bus ();
   snake_body_engine_if #(.X_W(X_W), .Y_W(Y_W), .LEN_W(SAT_LEN_W)) bus_sat ();

   snake_body_engine #(
      .GRID_W(GRID_W), .GRID_H(GRID_H), .X_W(X_W), .Y_W(Y_W),
      .MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN), .LEN_W(LEN_W)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   snake_body_engine #(
      .GRID_W(GRID_W), .GRID_H(GRID_H), .X_W(X_W), .Y_W(Y_W),
      .MAX_LEN(SAT_MAX), .INIT_LEN(INIT_LEN), .LEN_W(SAT_LEN_W)
   ) dut_sat (
      .clk(clk),
      .reset(reset),
      .bus(bus_sat)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   coord_t body[$];
   int     m_dir = 1;
   bit     m_dead = 1'b0;

   int tests_run = 0;
   int tests_failed = 0;
   bit chk_en = 1'b0;
   bit rd_chk = 1'b0;
   int exp_busy, exp_done, exp_dead, exp_hx, exp_hy, exp_len, exp_dir, exp_rd_x, exp_rd_y;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic st, input logic sp, input logic [1:0] d,
                                input logic g, input logic [LEN_W-1:0] idx);
      bus.start  = st;
      bus.step   = sp;
      bus.dir    = d;
      bus.grow   = g;
      bus.rd_idx = idx;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      rd_chk = 1'b0;
   endtask

   function automatic logic [LEN_W-1:0] rand_idx();
      return LEN_W'($urandom_range(0, 140));
   endfunction

   function automatic int opposite(input int d);
      case (d)
         0:       return 1;
         1:       return 0;
         2:       return 3;
         default: return 2;
      endcase
   endfunction

   function automatic coord_t next_head(input coord_t h, input int d);
      coord_t n;
      n = h;
      case (d)
         0:       n.x = h.x - 1;
         1:       n.x = h.x + 1;
         2:       n.y = h.y + 1;
         default: n.y = h.y - 1;
      endcase
      return n;
   endfunction

   function automatic bit on_wall(input coord_t c);
      return (c.x == 0) || (c.x == GRID_W - 1) || (c.y == 0) || (c.y == GRID_H - 1);
   endfunction

   task automatic exp_settled();
      exp_len  = body.size();
      exp_hx   = (body.size() > 0) ? body[0].x : 0;
      exp_hy   = (body.size() > 0) ? body[0].y : 0;
      exp_dir  = m_dir;
      exp_dead = m_dead;
   endtask

   task automatic junk();
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), rand_idx());
   endtask

   task automatic quiet();
      applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, rand_idx());
   endtask

   task automatic do_reset();
      quiet();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      body.delete();
      m_dir  = 1;
      m_dead = 1'b0;
      exp_busy = 0;
      exp_done = 0;
      exp_settled();
   endtask

   task automatic do_start(input bit with_step);
      applyStimulus(1'b1, with_step, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rand_idx());
      tick();
      quiet();
      body.delete();
      for (int i = 0; i < INIT_LEN; i++) body.push_back('{GRID_W / 2 - i, GRID_H / 2});
      m_dir  = 1;
      m_dead = 1'b0;
      exp_busy = 0;
      exp_done = 0;
      exp_settled();
   endtask

   task automatic idle_read(input int idx);
      applyStimulus(1'b0, 1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), LEN_W'(idx));
      tick();
      exp_rd_x = (idx < body.size()) ? body[idx].x : 0;
      exp_rd_y = (idx < body.size()) ? body[idx].y : 0;
      rd_chk   = 1'b1;
   endtask

   // One step request; walks the expected outputs through every cycle of the step.
   task automatic run_step(input int d, input bit g, output int obs_lat);
      coord_t nh;
      int     eff;
      int     lat;
      int     old_len;
      bit     wall;
      bit     hit;
      obs_lat = 0;
      applyStimulus(1'b0, 1'b1, 2'(d), g, rand_idx());
      if ((body.size() == 0) || m_dead) begin
         tick();
         quiet();
         return;
      end
      eff  = ((body.size() > 1) && (d == opposite(m_dir))) ? m_dir : d;
      nh   = next_head(body[0], eff);
      wall = on_wall(nh);
      hit  = 1'b0;
      lat  = 2;
      if (!wall) begin
         old_len = body.size();
         body.push_front(nh);
         if (!(g && (old_len < MAX_LEN))) void'(body.pop_back());
         lat = body.size() + 1;
         for (int k = 1; k < body.size(); k++) begin
            if ((body[k].x == nh.x) && (body[k].y == nh.y)) begin
               hit = 1'b1;
               lat = k + 2;
               break;
            end
         end
      end
      tick();
      junk();
      exp_busy = 1;
      exp_done = 0;
      for (int c = 2; c <= lat; c++) begin
         tick();
         junk();
         if ((c == 2) && !wall) begin
            m_dir = eff;
            exp_settled();
         end
         if (c == lat) begin
            if (wall || hit) m_dead = 1'b1;
            exp_dead = m_dead;
            exp_done = 1;
         end
         if ((bus.done === 1'b1) && (obs_lat == 0)) obs_lat = c;
      end
      tick();
      quiet();
      exp_busy = 0;
      exp_done = 0;
   endtask

   task automatic sat_step(input int exp_len_after);
      int lat;
      bus_sat.step = 1'b1;
      bus_sat.dir  = 2'b01;
      bus_sat.grow = 1'b1;
      tick();
      bus_sat.step = 1'b0;
      bus_sat.grow = 1'b0;
      lat = -1;
      for (int c = 1; c <= 20; c++) begin
         if (bus_sat.done === 1'b1) begin
            lat = c;
            break;
         end
         tick();
      end
      tick();
      checkOutput("sat_lat", 32'(lat), 32'(exp_len_after + 1));
      checkOutput("sat_len", 32'(bus_sat.length), 32'(exp_len_after));
   endtask

   task automatic sat_read(input int idx, input int ex, input int ey);
      bus_sat.rd_idx = SAT_LEN_W'(idx);
      tick();
      checkOutput("sat_rd_x", 32'(bus_sat.rd_x), 32'(ex));
      checkOutput("sat_rd_y", 32'(bus_sat.rd_y), 32'(ey));
   endtask

   // Cycle-by-cycle comparison of the DUT against the model expectations.
   always @(negedge clk) begin
      if (chk_en) begin
         checkOutput("busy",    32'(bus.busy),    exp_busy);
         checkOutput("done",    32'(bus.done),    exp_done);
         checkOutput("dead",    32'(bus.dead),    exp_dead);
         checkOutput("head_x",  32'(bus.head_x),  exp_hx);
         checkOutput("head_y",  32'(bus.head_y),  exp_hy);
         checkOutput("length",  32'(bus.length),  exp_len);
         checkOutput("cur_dir", 32'(bus.cur_dir), exp_dir);
         if (rd_chk) begin
            checkOutput("rd_x", 32'(bus.rd_x), exp_rd_x);
            checkOutput("rd_y", 32'(bus.rd_y), exp_rd_y);
         end
      end
   end

   // Directed scenarios followed by randomized play.
   initial begin
      int lat;
      int r;
      applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, '0);
      bus_sat.start  = 1'b0;
      bus_sat.step   = 1'b0;
      bus_sat.dir    = 2'b00;
      bus_sat.grow   = 1'b0;
      bus_sat.rd_idx = '0;
      tick();
      do_reset();
      chk_en = 1'b1;
      checkOutput("rst_len",     32'(bus.length),  0);
      checkOutput("rst_head_x",  32'(bus.head_x),  0);
      checkOutput("rst_head_y",  32'(bus.head_y),  0);
      checkOutput("rst_cur_dir", 32'(bus.cur_dir), 1);
      checkOutput("rst_busy",    32'(bus.busy),    0);
      checkOutput("rst_dead",    32'(bus.dead),    0);
      checkOutput("rst_rd_x",    32'(bus.rd_x),    0);

      run_step(1, 1'b0, lat);
      checkOutput("prestart_busy", 32'(bus.busy), 0);

      do_start(1'b0);
      for (int i = 0; i < 4; i++) begin
         idle_read(i);
         checkOutput("init_rd_x", 32'(bus.rd_x), 32'(80 - i));
         checkOutput("init_rd_y", 32'(bus.rd_y), 60);
      end
      checkOutput("init_len", 32'(bus.length), 4);
      run_step(1, 1'b0, lat);
      checkOutput("move_lat",    32'(lat),        5);
      checkOutput("move_head_x", 32'(bus.head_x), 81);
      checkOutput("move_head_y", 32'(bus.head_y), 60);
      checkOutput("move_dead",   32'(bus.dead),   0);

      do_start(1'b0);
      run_step(0, 1'b0, lat);
      checkOutput("rev_head_x",  32'(bus.head_x),  81);
      checkOutput("rev_cur_dir", 32'(bus.cur_dir), 1);

      do_start(1'b0);
      repeat (59) run_step(3, 1'b0, lat);
      checkOutput("wall_pre_y", 32'(bus.head_y), 1);
      run_step(3, 1'b0, lat);
      checkOutput("wall_lat",    32'(lat),        2);
      checkOutput("wall_dead",   32'(bus.dead),   1);
      checkOutput("wall_head_x", 32'(bus.head_x), 80);
      checkOutput("wall_head_y", 32'(bus.head_y), 1);
      run_step(3, 1'b0, lat);
      checkOutput("dead_step_busy", 32'(bus.busy), 0);
      do_start(1'b0);
      checkOutput("restart_dead", 32'(bus.dead), 0);

      do_start(1'b0);
      run_step(1, 1'b1, lat);
      run_step(2, 1'b0, lat);
      run_step(0, 1'b0, lat);
      run_step(3, 1'b0, lat);
      checkOutput("self_lat",    32'(lat),        6);
      checkOutput("self_dead",   32'(bus.dead),   1);
      checkOutput("self_head_x", 32'(bus.head_x), 80);
      checkOutput("self_len",    32'(bus.length), 5);

      do_start(1'b0);
      chk_en = 1'b0;
      applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, '0);
      tick();
      quiet();
      tick();
      tick();
      checkOutput("midscan_busy", 32'(bus.busy), 1);
      do_reset();
      checkOutput("midscan_rst_busy", 32'(bus.busy),   0);
      checkOutput("midscan_rst_done", 32'(bus.done),   0);
      checkOutput("midscan_rst_len",  32'(bus.length), 0);
      chk_en = 1'b1;
      repeat (6) idle_read(0);

      do_start(1'b1);
      checkOutput("race_head_x", 32'(bus.head_x), 80);
      checkOutput("race_len",    32'(bus.length), 4);
      idle_read(0);
      checkOutput("race_busy", 32'(bus.busy), 0);
      checkOutput("race_rd_x", 32'(bus.rd_x), 80);

      bus_sat.start = 1'b1;
      tick();
      bus_sat.start = 1'b0;
      sat_step(5);
      sat_step(6);
      sat_step(6);
      sat_read(0, 83, 60);
      sat_read(5, 78, 60);
      sat_read(6, 0, 0);

      for (int it = 0; it < 600; it++) begin
         r = $urandom_range(0, 99);
         if (r < 2) do_reset();
         else if ((r < 8) || (m_dead && (r < 40))) do_start(r % 2 == 1);
         else if (r < 15) idle_read($urandom_range(0, body.size() + 2));
         else run_step($urandom_range(0, 3), ($urandom_range(0, 3) == 0), lat);
      end
      repeat (2) tick();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
